// File: rtl/pc_redirect_ctrl.sv
// PC owner for the fetch stage: arbitrates EX/ID redirects, stall and increment, drives squashes and refill tracking.
// Optional redirect statistics counters enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter int unsigned REFILL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_redirect,
    input  logic [15:0] ex_new_pc,
    input  logic        id_redirect,
    input  logic [15:0] id_target,
    output logic [15:0] pc_out,
    output logic        flush_ifid,
    output logic        flush_idrr,
    output logic        flush_rrex,
    output logic        refill
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [15:0] ex_redirect_cnt,
    output logic [15:0] id_redirect_cnt
`endif
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = $clog2(REFILL_CYCLES) + 1;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_REFILL = 1'b1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFILL_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             ex_take;
    logic             id_take;

    // EX is older than anything stalled behind it, so it beats both stall and ID.
    assign ex_take = ex_redirect & ex_valid;
    assign id_take = id_redirect & ~stall & ~ex_take;

    // Squashes are same-cycle; suppressed while reset is held.
    assign flush_ifid = rst_n & (ex_take | id_take);
    assign flush_idrr = rst_n & ex_take;
    assign flush_rrex = rst_n & ex_take;

    assign pc_out = pc_q;
    assign refill = (state_q == ST_REFILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;

        if (ex_take) begin
            pc_d = ex_new_pc;
        end else if (id_take) begin
            pc_d = id_target;
        end else if (!stall) begin
            pc_d = pc_q + PC_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                if (ex_take) begin
                    state_d = ST_REFILL;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_REFILL: begin
                if (ex_take) begin
                    cnt_d = CNT_RELOAD;
                end else if (stall) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] ex_cnt_q;
    logic [15:0] id_cnt_q;

    // Saturating event counters for redirect profiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_cnt_q <= '0;
            id_cnt_q <= '0;
        end else begin
            if (ex_take && (ex_cnt_q != 16'hFFFF)) begin
                ex_cnt_q <= ex_cnt_q + 16'(1);
            end
            if (id_take && (id_cnt_q != 16'hFFFF)) begin
                id_cnt_q <= id_cnt_q + 16'(1);
            end
        end
    end

    assign ex_redirect_cnt = ex_cnt_q;
    assign id_redirect_cnt = id_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl: reset, increment, redirects, stall interaction, refill window.
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic        ex_redirect;
    logic [15:0] ex_new_pc;
    logic        id_redirect;
    logic [15:0] id_target;
    logic [15:0] pc_out;
    logic        flush_ifid;
    logic        flush_idrr;
    logic        flush_rrex;
    logic        refill;
`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] ex_redirect_cnt;
    logic [15:0] id_redirect_cnt;
`endif

    int checks;
    int failures;

    pc_redirect_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_redirect(ex_redirect),
        .ex_new_pc  (ex_new_pc),
        .id_redirect(id_redirect),
        .id_target  (id_target),
        .pc_out     (pc_out),
        .flush_ifid (flush_ifid),
        .flush_idrr (flush_idrr),
        .flush_rrex (flush_rrex),
        .refill     (refill)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .ex_redirect_cnt(ex_redirect_cnt),
        .id_redirect_cnt(id_redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stall       = 1'b0;
        ex_valid    = 1'b0;
        ex_redirect = 1'b0;
        ex_new_pc   = 16'h0000;
        id_redirect = 1'b0;
        id_target   = 16'h0000;
    endtask

    task automatic check_flushes(input string tag, input logic f_ifid, input logic f_idrr, input logic f_rrex);
        check({tag, "_ifid"}, 16'(flush_ifid), 16'(f_ifid));
        check({tag, "_idrr"}, 16'(flush_idrr), 16'(f_idrr));
        check({tag, "_rrex"}, 16'(flush_rrex), 16'(f_rrex));
    endtask

    task automatic ex_jump(input logic [15:0] target);
        ex_valid    = 1'b1;
        ex_redirect = 1'b1;
        ex_new_pc   = target;
        #1;
        check_flushes("ex_jump", 1'b1, 1'b1, 1'b1);
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        rst_n = 1'b0;

        // A pending EX redirect during reset must not produce flushes.
        ex_valid    = 1'b1;
        ex_redirect = 1'b1;
        ex_new_pc   = 16'h1234;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc", pc_out, 16'h0000);
        check("rst_refill", 16'(refill), 16'h0000);
        check_flushes("rst", 1'b0, 1'b0, 1'b0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch after reset.
        for (int i = 0; i < 5; i++) begin
            check("seq_pc", pc_out, 16'(i));
            check("seq_refill", 16'(refill), 16'h0000);
            check_flushes("seq", 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        repeat (11) next_cycle();
        check("pc_at_10", pc_out, 16'h0010);

        // EX redirect opens a 3-cycle refill window.
        ex_jump(16'h0100);
        check("exr_pc0", pc_out, 16'h0100);
        check("exr_ref0", 16'(refill), 16'h0001);
        next_cycle();
        check("exr_pc1", pc_out, 16'h0101);
        check("exr_ref1", 16'(refill), 16'h0001);
        next_cycle();
        check("exr_pc2", pc_out, 16'h0102);
        check("exr_ref2", 16'(refill), 16'h0001);
        next_cycle();
        check("exr_pc3", pc_out, 16'h0103);
        check("exr_ref3", 16'(refill), 16'h0000);

        // Redirect on a bubble is ignored.
        ex_redirect = 1'b1;
        ex_new_pc   = 16'h0BAD;
        #1;
        check_flushes("bubble", 1'b0, 1'b0, 1'b0);
        next_cycle();
        clear_inputs();
        check("bubble_pc", pc_out, 16'h0104);

        // ID redirect waits out the stall.
        stall       = 1'b1;
        id_redirect = 1'b1;
        id_target   = 16'h0200;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("idst_pc", pc_out, 16'h0104);
            check_flushes("idst", 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        stall = 1'b0;
        #1;
        check_flushes("idgo", 1'b1, 1'b0, 1'b0);
        next_cycle();
        clear_inputs();
        check("idgo_pc", pc_out, 16'h0200);
        check("idgo_refill", 16'(refill), 16'h0000);

        // EX beats both stall and a simultaneous ID redirect.
        stall       = 1'b1;
        id_redirect = 1'b1;
        id_target   = 16'h0200;
        ex_jump(16'h0300);
        check("both_pc", pc_out, 16'h0300);
        check("both_refill", 16'(refill), 16'h0001);
        next_cycle();
        check("both_pc1", pc_out, 16'h0301);

        // Second EX redirect mid-refill reloads; a stall cycle does not consume the window.
        ex_jump(16'h0400);
        stall = 1'b1;
        #1;
        check("rl_pc_st", pc_out, 16'h0400);
        check("rl_ref_st", 16'(refill), 16'h0001);
        next_cycle();
        stall = 1'b0;
        check("rl_pc0", pc_out, 16'h0400);
        check("rl_ref0", 16'(refill), 16'h0001);
        next_cycle();
        check("rl_pc1", pc_out, 16'h0401);
        check("rl_ref1", 16'(refill), 16'h0001);
        next_cycle();
        check("rl_pc2", pc_out, 16'h0402);
        check("rl_ref2", 16'(refill), 16'h0001);
        next_cycle();
        check("rl_pc3", pc_out, 16'h0403);
        check("rl_ref3", 16'(refill), 16'h0000);

        // PC increment wraps at the top of the address space.
        ex_jump(16'hFFFF);
        check("wrap_pc0", pc_out, 16'hFFFF);
        next_cycle();
        check("wrap_pc1", pc_out, 16'h0000);

        // Asynchronous reset in the middle of a refill window.
        ex_jump(16'h0100);
        next_cycle();
        check("ar_pc_pre", pc_out, 16'h0101);
        check("ar_ref_pre", 16'(refill), 16'h0001);
        rst_n = 1'b0;
        #1;
        check("ar_pc", pc_out, 16'h0000);
        check("ar_refill", 16'(refill), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        check("ar_after_pc", pc_out, 16'h0001);
        check("ar_after_ref", 16'(refill), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
